// File: rtl/syn_mem_seq_pkg.sv
// Shared definitions for the Synapse DMEM address sequencer: address width,
// default write-pipeline depth and the sequencer state encoding.
package syn_mem_seq_pkg;

    // Width of a Synapse local data memory address.
    localparam int ADDR_DMEM = 6;

    // Cycles from a read issue to the write of its result
    // (multiplier register plus adder-operand register).
    localparam int LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // Address accumulation; the sum wraps silently at 2^ADDR_DMEM.
    function automatic logic [ADDR_DMEM-1:0] addr_add(
        input logic [ADDR_DMEM-1:0] a,
        input logic [ADDR_DMEM-1:0] b
    );
        return a + b;
    endfunction

endpackage

// File: rtl/syn_wr_pipe.sv
// LAT-deep delay line of {valid, write address}. Shifts every cycle because the
// Synapse datapath never stalls; flush clears only the valid bits.
module syn_wr_pipe import syn_mem_seq_pkg::*; #(
    parameter int LAT = LAT_DEFAULT,
    parameter int AW  = ADDR_DMEM
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic          pending
);

    logic [LAT-1:0] valid_r;
    logic [AW-1:0]  addr_r [LAT];
    logic           pending_s;

    // Shift valid and address one stage per cycle; flush drops all valids.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                addr_r[i] <= {AW{1'b0}};
            end
        end else begin
            if (flush) begin
                valid_r <= {LAT{1'b0}};
            end else begin
                valid_r[0] <= in_valid;
                for (int i = 1; i < LAT; i++) begin
                    valid_r[i] <= valid_r[i-1];
                end
            end
            addr_r[0] <= in_addr;
            for (int i = 1; i < LAT; i++) begin
                addr_r[i] <= addr_r[i-1];
            end
        end
    end

    // Entries that will still be in the line after this cycle's tail write.
    always_comb begin
        pending_s = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            pending_s = pending_s | valid_r[i];
        end
    end

    assign out_valid = valid_r[LAT-1];
    assign out_addr  = addr_r[LAT-1];
    assign pending   = pending_s;

endmodule

// File: rtl/syn_mem_seq.sv
// Address sequencer for one Synapse's local data memory: accepts a strided
// vector command, streams read addresses and, LAT cycles later, the matching
// write addresses and write strobe.
module syn_mem_seq import syn_mem_seq_pkg::*; #(
    parameter int LAT   = LAT_DEFAULT,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_DMEM-1:0] cmd_r_base,
    input  logic [ADDR_DMEM-1:0] cmd_r_stride,
    input  logic [ADDR_DMEM-1:0] cmd_w_base,
    input  logic [ADDR_DMEM-1:0] cmd_w_stride,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic                 hold,
    input  logic                 abort,
    output logic [ADDR_DMEM-1:0] r_addr,
    output logic                 rd_en,
    output logic [ADDR_DMEM-1:0] w_addr,
    output logic                 we_ram,
    output logic                 busy,
    output logic                 done
);

    seq_state_e           state_r;
    seq_state_e           fsm_next_s;
    seq_state_e           state_s;
    logic [ADDR_DMEM-1:0] rptr_r;
    logic [ADDR_DMEM-1:0] wptr_r;
    logic [ADDR_DMEM-1:0] rstride_r;
    logic [ADDR_DMEM-1:0] wstride_r;
    logic [LEN_W-1:0]     len_r;
    logic [LEN_W-1:0]     cnt_r;
    logic                 accept_s;
    logic                 issue_s;
    logic                 pipe_valid_s;
    logic [ADDR_DMEM-1:0] pipe_addr_s;
    logic                 pending_s;

    // Write-side delay line; each read issue pushes the current write pointer.
    syn_wr_pipe #(
        .LAT (LAT),
        .AW  (ADDR_DMEM)
    ) u_wr_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .in_valid  (issue_s),
        .in_addr   (wptr_r),
        .out_valid (pipe_valid_s),
        .out_addr  (pipe_addr_s),
        .pending   (pending_s)
    );

    // Next-state logic; abort overrides every transition and returns to IDLE.
    always_comb begin
        fsm_next_s = state_r;
        accept_s   = 1'b0;
        issue_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && !abort) begin
                    accept_s = 1'b1;
                    if (cmd_len == {LEN_W{1'b0}}) begin
                        fsm_next_s = ST_DONE;
                    end else begin
                        fsm_next_s = ST_RUN;
                    end
                end else begin
                    fsm_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!hold && !abort) begin
                    issue_s = 1'b1;
                    if (cnt_r == len_r - LEN_W'(1)) begin
                        fsm_next_s = ST_DRAIN;
                    end else begin
                        fsm_next_s = ST_RUN;
                    end
                end else begin
                    fsm_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pending_s) begin
                    fsm_next_s = ST_DRAIN;
                end else begin
                    fsm_next_s = ST_DONE;
                end
            end
            ST_DONE: begin
                fsm_next_s = ST_IDLE;
            end
            default: begin
                fsm_next_s = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            state_s = fsm_next_s;
        end
    end

    // Output decode; addresses read as zero whenever their strobe is low.
    always_comb begin
        cmd_ready = (state_r == ST_IDLE) && !abort;
        busy      = (state_r != ST_IDLE);
        done      = (state_r == ST_DONE) && !abort;
        rd_en     = issue_s;
        we_ram    = pipe_valid_s && !abort;
        if (issue_s) begin
            r_addr = rptr_r;
        end else begin
            r_addr = {ADDR_DMEM{1'b0}};
        end
        if (pipe_valid_s && !abort) begin
            w_addr = pipe_addr_s;
        end else begin
            w_addr = {ADDR_DMEM{1'b0}};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command latch on handshake; pointer and counter advance on each read issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_r    <= {ADDR_DMEM{1'b0}};
            wptr_r    <= {ADDR_DMEM{1'b0}};
            rstride_r <= {ADDR_DMEM{1'b0}};
            wstride_r <= {ADDR_DMEM{1'b0}};
            len_r     <= {LEN_W{1'b0}};
            cnt_r     <= {LEN_W{1'b0}};
        end else if (accept_s) begin
            rptr_r    <= cmd_r_base;
            wptr_r    <= cmd_w_base;
            rstride_r <= cmd_r_stride;
            wstride_r <= cmd_w_stride;
            len_r     <= cmd_len;
            cnt_r     <= {LEN_W{1'b0}};
        end else if (issue_s) begin
            rptr_r <= addr_add(rptr_r, rstride_r);
            wptr_r <= addr_add(wptr_r, wstride_r);
            cnt_r  <= cnt_r + LEN_W'(1);
        end
    end

endmodule
